// File: rtl/ins_mem_access_pkg.sv
// Shared definitions for the memory-access stage: FSM encoding, timeout default,
// and RV32 width constants.
package ins_mem_access_pkg;

  localparam int XLEN            = 32;
  localparam int REG_ADDR_W      = 5;
  localparam int CNT_W           = 8;
  localparam int TIMEOUT_DEFAULT = 255;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } ma_state_e;

endpackage

// File: rtl/ins_mem_access.sv
// RV32 memory-access stage: issues word loads/stores on a req/ack port,
// stalls upstream while an access is outstanding, and registers MA/WB results.
module ins_mem_access
  import ins_mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [XLEN-1:0]       ma_pc_plus_4_in,
  input  logic [XLEN-1:0]       ma_alu_result_in,
  input  logic [XLEN-1:0]       ma_write_data_in,
  input  logic [REG_ADDR_W-1:0] ma_rd_addr_in,
  input  logic                  ma_mem_read_in,
  input  logic                  ma_mem_write_in,
  input  logic                  ma_reg_write_in,
  input  logic                  ma_mem_to_reg_in,
  output logic                  dmem_req_out,
  output logic                  dmem_we_out,
  output logic [XLEN-1:0]       dmem_addr_out,
  output logic [XLEN-1:0]       dmem_wdata_out,
  input  logic [XLEN-1:0]       dmem_rdata_in,
  input  logic                  dmem_ack_in,
  output logic                  mem_stall_out,
  output logic [XLEN-1:0]       wb_pc_plus_4_out,
  output logic [REG_ADDR_W-1:0] wb_rd_addr_out,
  output logic [XLEN-1:0]       wb_write_data_out,
  output logic                  wb_reg_write_en_out,
  output logic                  misaligned_err_out,
  output logic                  bus_err_out
);

  // Last WAIT count before the access is abandoned.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  ma_state_e        state;
  logic [CNT_W-1:0] cnt;

  logic access;
  logic aligned;
  logic rd_en;
  logic timeout_hit;

  // Decode the incoming EX/MA controls and derive the combinational stall.
  always_comb begin
    access      = ma_mem_read_in | ma_mem_write_in;
    aligned     = (ma_alu_result_in[1:0] == 2'b00);
    rd_en       = ma_reg_write_in & (ma_rd_addr_in != '0);
    timeout_hit = (state == ST_WAIT) & ~dmem_ack_in & (cnt == CNT_LAST);
    mem_stall_out = 1'b0;
    if (state == ST_IDLE)
      mem_stall_out = access & aligned;
    else
      mem_stall_out = ~dmem_ack_in & ~timeout_hit;
  end

  // FSM, data-memory request registers and MA/WB pipeline registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state               <= ST_IDLE;
      cnt                 <= '0;
      dmem_req_out        <= 1'b0;
      dmem_we_out         <= 1'b0;
      dmem_addr_out       <= '0;
      dmem_wdata_out      <= '0;
      wb_pc_plus_4_out    <= '0;
      wb_rd_addr_out      <= '0;
      wb_write_data_out   <= '0;
      wb_reg_write_en_out <= 1'b0;
      misaligned_err_out  <= 1'b0;
      bus_err_out         <= 1'b0;
    end else begin
      misaligned_err_out <= 1'b0;
      bus_err_out        <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (access && aligned) begin
            // Launch the access; WB holds its previous contents meanwhile.
            dmem_req_out   <= 1'b1;
            dmem_we_out    <= ma_mem_write_in;
            dmem_addr_out  <= {ma_alu_result_in[XLEN-1:2], 2'b00};
            dmem_wdata_out <= ma_write_data_in;
            cnt            <= '0;
            state          <= ST_WAIT;
          end else begin
            // Plain pass-through, or a misaligned access squashed in place.
            wb_pc_plus_4_out    <= ma_pc_plus_4_in;
            wb_rd_addr_out      <= ma_rd_addr_in;
            wb_write_data_out   <= ma_alu_result_in;
            wb_reg_write_en_out <= rd_en & ~access;
            misaligned_err_out  <= access;
          end
        end
        ST_WAIT: begin
          if (dmem_ack_in) begin
            dmem_req_out        <= 1'b0;
            wb_pc_plus_4_out    <= ma_pc_plus_4_in;
            wb_rd_addr_out      <= ma_rd_addr_in;
            wb_write_data_out   <= ma_mem_to_reg_in ? dmem_rdata_in : ma_alu_result_in;
            wb_reg_write_en_out <= rd_en;
            state               <= ST_IDLE;
          end else if (cnt == CNT_LAST) begin
            // Nobody answered: drop the request and retire without write-back.
            dmem_req_out        <= 1'b0;
            wb_pc_plus_4_out    <= ma_pc_plus_4_in;
            wb_rd_addr_out      <= ma_rd_addr_in;
            wb_write_data_out   <= ma_alu_result_in;
            wb_reg_write_en_out <= 1'b0;
            bus_err_out         <= 1'b1;
            state               <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ins_mem_access.sv
// Scenario bench for the memory-access stage with a WB scoreboard queue.
module tb_ins_mem_access;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] ma_pc_plus_4_in, ma_alu_result_in, ma_write_data_in;
  logic [4:0]  ma_rd_addr_in;
  logic        ma_mem_read_in, ma_mem_write_in, ma_reg_write_in, ma_mem_to_reg_in;
  logic        dmem_req_out, dmem_we_out;
  logic [31:0] dmem_addr_out, dmem_wdata_out, dmem_rdata_in;
  logic        dmem_ack_in, mem_stall_out;
  logic [31:0] wb_pc_plus_4_out, wb_write_data_out;
  logic [4:0]  wb_rd_addr_out;
  logic        wb_reg_write_en_out, misaligned_err_out, bus_err_out;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        en;
  } wb_t;

  wb_t sb[$];
  wb_t exp_wb;
  int  tests = 0;
  int  fails = 0;

  ins_mem_access #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .ma_pc_plus_4_in(ma_pc_plus_4_in), .ma_alu_result_in(ma_alu_result_in),
    .ma_write_data_in(ma_write_data_in), .ma_rd_addr_in(ma_rd_addr_in),
    .ma_mem_read_in(ma_mem_read_in), .ma_mem_write_in(ma_mem_write_in),
    .ma_reg_write_in(ma_reg_write_in), .ma_mem_to_reg_in(ma_mem_to_reg_in),
    .dmem_req_out(dmem_req_out), .dmem_we_out(dmem_we_out),
    .dmem_addr_out(dmem_addr_out), .dmem_wdata_out(dmem_wdata_out),
    .dmem_rdata_in(dmem_rdata_in), .dmem_ack_in(dmem_ack_in),
    .mem_stall_out(mem_stall_out),
    .wb_pc_plus_4_out(wb_pc_plus_4_out), .wb_rd_addr_out(wb_rd_addr_out),
    .wb_write_data_out(wb_write_data_out), .wb_reg_write_en_out(wb_reg_write_en_out),
    .misaligned_err_out(misaligned_err_out), .bus_err_out(bus_err_out)
  );

  always #5 clk = ~clk;

  function automatic wb_t cur_wb();
    return '{pc: wb_pc_plus_4_out, rd: wb_rd_addr_out, data: wb_write_data_out, en: wb_reg_write_en_out};
  endfunction

  task automatic drive(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] wd,
                       input logic [4:0] rd, input logic rdm, input logic wrm,
                       input logic rw, input logic mtr);
    ma_pc_plus_4_in = pc; ma_alu_result_in = alu; ma_write_data_in = wd;
    ma_rd_addr_in = rd; ma_mem_read_in = rdm; ma_mem_write_in = wrm;
    ma_reg_write_in = rw; ma_mem_to_reg_in = mtr;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    dmem_rdata_in = 0; dmem_ack_in = 0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({dmem_req_out, dmem_we_out, dmem_addr_out, dmem_wdata_out, cur_wb(),
         misaligned_err_out, bus_err_out} !== '0) begin
      fails++; $display("FAIL reset_state: outputs not all zero, wb=%h req=%b", cur_wb(), dmem_req_out);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  // Non-memory op: one-cycle latency, no stall, no request.
  task automatic test_alu(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] alu, input logic rw);
    drive(pc, alu, 32'h5555_AAAA, rd, 0, 0, rw, 0);
    sb.push_back('{pc: pc, rd: rd, data: alu, en: rw && (rd != 0)});
    #1;
    tests++;
    if (mem_stall_out !== 1'b0) begin fails++; $display("FAIL alu_stall: got %b want 0", mem_stall_out); end
    @(posedge clk); #1;
    exp_wb = sb.pop_front();
    tests++;
    if (cur_wb() !== exp_wb) begin fails++; $display("FAIL alu_wb: got %h want %h", cur_wb(), exp_wb); end
    tests++;
    if (dmem_req_out !== 1'b0) begin fails++; $display("FAIL alu_req: got %b want 0", dmem_req_out); end
  endtask

  // Aligned access answered in WAIT cycle ack_k.
  task automatic test_mem(input logic st, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [4:0] rd, input int ack_k, input logic [31:0] rdata);
    int stalls = 0;
    int req_cyc = 0;
    bit bad_hold = 0;
    drive(32'h0000_4000 + addr, addr, wd, rd, !st, st, !st, !st);
    sb.push_back('{pc: 32'h0000_4000 + addr, rd: rd, data: st ? addr : rdata, en: !st && (rd != 0)});
    #1;
    if (mem_stall_out) stalls++;
    @(posedge clk); #1;
    tests++;
    if ({dmem_req_out, dmem_we_out, dmem_addr_out, dmem_wdata_out} !== {1'b1, st, addr, wd}) begin
      fails++; $display("FAIL mem_issue: got req=%b we=%b a=%h d=%h want 1 %b %h %h",
                        dmem_req_out, dmem_we_out, dmem_addr_out, dmem_wdata_out, st, addr, wd);
    end
    for (int c = 1; c <= 50; c++) begin
      if (dmem_req_out) req_cyc++;
      if (dmem_addr_out !== addr || dmem_we_out !== st || dmem_wdata_out !== wd || dmem_req_out !== 1'b1)
        bad_hold = 1;
      if (c == ack_k) begin
        dmem_ack_in = 1; dmem_rdata_in = rdata;
        #1;
        if (mem_stall_out) stalls++;
        @(posedge clk); #1;
        dmem_ack_in = 0; dmem_rdata_in = 32'h0BAD_0BAD;
        break;
      end
      #1;
      if (mem_stall_out) stalls++;
      @(posedge clk); #1;
    end
    tests++;
    if (bad_hold) begin fails++; $display("FAIL mem_hold: req/addr/we/wdata changed during WAIT"); end
    tests++;
    if (stalls != ack_k) begin fails++; $display("FAIL mem_stall_cycles: got %0d want %0d", stalls, ack_k); end
    tests++;
    if (req_cyc != ack_k) begin fails++; $display("FAIL mem_req_cycles: got %0d want %0d", req_cyc, ack_k); end
    tests++;
    if (dmem_req_out !== 1'b0) begin fails++; $display("FAIL mem_req_drop: got %b want 0", dmem_req_out); end
    exp_wb = sb.pop_front();
    tests++;
    if (cur_wb() !== exp_wb) begin fails++; $display("FAIL mem_wb: got %h want %h", cur_wb(), exp_wb); end
  endtask

  task automatic test_misaligned();
    drive(32'h0000_0308, 32'h0000_0102, 0, 5'd3, 1, 0, 1, 1);
    sb.push_back('{pc: 32'h0000_0308, rd: 5'd3, data: 32'h0000_0102, en: 1'b0});
    #1;
    tests++;
    if (mem_stall_out !== 1'b0) begin fails++; $display("FAIL mis_stall: got %b want 0", mem_stall_out); end
    @(posedge clk); #1;
    exp_wb = sb.pop_front();
    tests++;
    if ({misaligned_err_out, dmem_req_out} !== 2'b10) begin
      fails++; $display("FAIL mis_pulse: err=%b req=%b want 1 0", misaligned_err_out, dmem_req_out);
    end
    tests++;
    if (cur_wb() !== exp_wb) begin fails++; $display("FAIL mis_wb: got %h want %h", cur_wb(), exp_wb); end
    test_alu(32'h0000_030C, 5'd4, 32'h0000_0044, 1'b1);
    tests++;
    if (misaligned_err_out !== 1'b0) begin fails++; $display("FAIL mis_pulse_len: got %b want 0", misaligned_err_out); end
  endtask

  task automatic test_timeout();
    int wait_stalls = 0;
    int rel_cyc = 0;
    drive(32'h0000_0504, 32'h0000_0300, 0, 5'd9, 1, 0, 1, 1);
    sb.push_back('{pc: 32'h0000_0504, rd: 5'd9, data: 32'h0000_0300, en: 1'b0});
    @(posedge clk); #1;
    for (int c = 1; c <= 20; c++) begin
      #1;
      if (!mem_stall_out) begin rel_cyc = c; break; end
      wait_stalls++;
      @(posedge clk); #1;
    end
    tests++;
    if (rel_cyc != TO || wait_stalls != TO - 1) begin
      fails++; $display("FAIL to_release: released in cycle %0d after %0d stalls, want %0d after %0d",
                        rel_cyc, wait_stalls, TO, TO - 1);
    end
    @(posedge clk); #1;
    exp_wb = sb.pop_front();
    tests++;
    if ({bus_err_out, dmem_req_out} !== 2'b10) begin
      fails++; $display("FAIL to_pulse: err=%b req=%b want 1 0", bus_err_out, dmem_req_out);
    end
    tests++;
    if (cur_wb() !== exp_wb) begin fails++; $display("FAIL to_wb: got %h want %h", cur_wb(), exp_wb); end
    // Stray ack arrives while idle with a non-memory op: must be ignored.
    dmem_ack_in = 1; dmem_rdata_in = 32'hFFFF_0000;
    test_alu(32'h0000_0508, 5'd10, 32'h0000_00AA, 1'b1);
    dmem_ack_in = 0;
    tests++;
    if (bus_err_out !== 1'b0) begin fails++; $display("FAIL to_pulse_len: got %b want 0", bus_err_out); end
  endtask

  task automatic test_reset_mid_wait();
    drive(32'h0000_0704, 32'h0000_0400, 0, 5'd6, 1, 0, 1, 1);
    @(posedge clk); #1;
    tests++;
    if (dmem_req_out !== 1'b1) begin fails++; $display("FAIL rmw_pre_req: got %b want 1", dmem_req_out); end
    #2 rst = 1'b0;
    #1;
    tests++;
    if ({dmem_req_out, cur_wb()} !== '0) begin
      fails++; $display("FAIL rmw_async: req=%b wb=%h want all zero", dmem_req_out, cur_wb());
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    test_alu(32'h0000_0800, 5'd12, 32'h0000_0C0C, 1'b1);
  endtask

  initial begin
    fork
      begin
        test_reset();
        test_alu(32'h0000_0004, 5'd5, 32'h0000_1234, 1'b1);
        test_alu(32'h0000_0008, 5'd0, 32'h0000_7777, 1'b1);
        test_alu(32'h0000_000C, 5'd8, 32'h1234_5678, 1'b0);
        test_mem(1'b0, 32'h0000_0100, 32'h0, 5'd7, 3, 32'hDEAD_BEEF);
        test_mem(1'b1, 32'h0000_0200, 32'hCAFE_F00D, 5'd0, 1, 32'h0);
        test_mem(1'b0, 32'h0000_0104, 32'h0, 5'd11, 1, 32'h0102_0304);
        test_misaligned();
        test_timeout();
        test_mem(1'b0, 32'h0000_0108, 32'h0, 5'd13, 2, 32'hA5A5_5A5A);
        test_reset_mid_wait();
      end
      begin
        #20000;
        fails++;
        $display("FAIL watchdog: bench did not finish within time limit");
      end
    join_any
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
